ssd1306_cmd_ctrl: RTL and testbench

- Command/addressing controller between the SPI byte deserializer and the framebuffer write port of the SSD1306-to-VGA bridge.
- Decodes SSD1306 command bytes (dc=0), holds display configuration and the GDDRAM column/page pointers.
- Converts data bytes (dc=1) into byte-wide framebuffer writes at the correct address per addressing mode.
- Single clock domain `clk`; the input byte stream is already synchronized to it.

---
 rtl/ssd1306_cmd_ctrl_if.sv | 27 ++
 rtl/ssd1306_cmd_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_ssd1306_cmd_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ssd1306_cmd_ctrl_if.sv
// Byte-stream and framebuffer-write bundle for the SSD1306 command controller.
// Latency: none (wires only).
// Backpressure: none; the byte stream and writes are strobes, one byte per clk.
interface ssd1306_cmd_ctrl_if #(
   parameter int COL_W  = 7,
   parameter int PAGE_W = 3
) ();
   logic                    byte_valid;
   logic [7:0]              byte_data;
   logic                    byte_dc;
   logic                    cs_rise;
   logic                    wr_en;
   logic [COL_W+PAGE_W-1:0] wr_addr;
   logic [7:0]              wr_data;

   // Upstream side: SPI deserializer feeding bytes, framebuffer side observed.
   modport master (
      output byte_valid, byte_data, byte_dc, cs_rise,
      input  wr_en, wr_addr, wr_data
   );

   // Controller side.
   modport slave (
      input  byte_valid, byte_data, byte_dc, cs_rise,
      output wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/ssd1306_cmd_ctrl.sv
// SSD1306 command decoder, config registers and GDDRAM pointer/framebuffer write generator.
// Latency: data byte -> wr_en one clk later; commands take effect on the edge after their last byte.
// Backpressure: none; accepts one byte per clk. Optional flip opcodes: define SSD1306_CTRL_FLIP_EN.
module ssd1306_cmd_ctrl #(
   parameter int         COL_W        = 7,
   parameter int         PAGE_W       = 3,
   parameter logic [7:0] CONTRAST_RST = 8'h7F
) (
   input  logic                 clk,
   input  logic                 rst,
   ssd1306_cmd_ctrl_if.slave    bus,
   output logic                 disp_on,
   output logic                 invert,
   output logic [7:0]           contrast,
   output logic                 flip_h,
   output logic                 flip_v
);

   typedef enum logic [1:0] {IDLE, ARG1, ARG2, SKIP1} state_t;

   localparam logic [1:0] MODE_HORZ = 2'd0;
   localparam logic [1:0] MODE_VERT = 2'd1;
   localparam logic [1:0] MODE_PAGE = 2'd2;

   state_t              state, state_nxt;
   logic [7:0]          opcode, opcode_nxt;
   logic [COL_W-1:0]    arg, arg_nxt;          // first argument of 0x21/0x22
   logic [1:0]          mode, mode_nxt;
   logic [COL_W-1:0]    col_start, col_start_nxt, col_end, col_end_nxt, col_ptr, col_ptr_nxt;
   logic [PAGE_W-1:0]   page_start, page_start_nxt, page_end, page_end_nxt, page_ptr, page_ptr_nxt;
   logic                disp_on_nxt, invert_nxt;
   logic [7:0]          contrast_nxt;
   logic                wr_en_nxt;
   logic [COL_W+PAGE_W-1:0] wr_addr_nxt;
   logic [7:0]          wr_data_nxt;
   logic                col_wrap, page_wrap;
   logic [COL_W-1:0]    col_inc;
   logic [PAGE_W-1:0]   page_inc;
`ifdef SSD1306_CTRL_FLIP_EN
   logic                flip_h_nxt, flip_v_nxt;
`endif

   // Pointer successors: wrap to start on reaching end, otherwise count modulo 2^W.
   always_comb begin
      col_wrap  = (col_ptr == col_end);
      page_wrap = (page_ptr == page_end);
      col_inc   = col_wrap  ? col_start  : col_ptr + COL_W'(1);
      page_inc  = page_wrap ? page_start : page_ptr + PAGE_W'(1);
   end

   // Byte decode: next FSM state, config/pointer updates and the registered write.
   always_comb begin
      state_nxt      = state;
      opcode_nxt     = opcode;
      arg_nxt        = arg;
      mode_nxt       = mode;
      col_start_nxt  = col_start;
      col_end_nxt    = col_end;
      col_ptr_nxt    = col_ptr;
      page_start_nxt = page_start;
      page_end_nxt   = page_end;
      page_ptr_nxt   = page_ptr;
      disp_on_nxt    = disp_on;
      invert_nxt     = invert;
      contrast_nxt   = contrast;
      wr_en_nxt      = 1'b0;
      wr_addr_nxt    = bus.wr_addr;
      wr_data_nxt    = bus.wr_data;
`ifdef SSD1306_CTRL_FLIP_EN
      flip_h_nxt     = flip_h;
      flip_v_nxt     = flip_v;
`endif
      if (bus.byte_valid) begin
         if (bus.byte_dc) begin
            // Data byte: write at the current address, advance, drop any pending command.
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = {page_ptr, col_ptr};
            wr_data_nxt = bus.byte_data;
            state_nxt   = IDLE;
            case (mode)
               MODE_HORZ: begin
                  col_ptr_nxt = col_inc;
                  if (col_wrap) page_ptr_nxt = page_inc;
               end
               MODE_VERT: begin
                  page_ptr_nxt = page_inc;
                  if (page_wrap) col_ptr_nxt = col_inc;
               end
               default: col_ptr_nxt = col_inc;
            endcase
         end else begin
            case (state)
               IDLE: begin
                  opcode_nxt = bus.byte_data;
                  case (bus.byte_data)
                     8'h20, 8'h21, 8'h22, 8'h81:                      state_nxt = ARG1;
                     8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D: state_nxt = SKIP1;
                     8'hAE: disp_on_nxt = 1'b0;
                     8'hAF: disp_on_nxt = 1'b1;
                     8'hA6: invert_nxt  = 1'b0;
                     8'hA7: invert_nxt  = 1'b1;
`ifdef SSD1306_CTRL_FLIP_EN
                     8'hA0: flip_h_nxt  = 1'b0;
                     8'hA1: flip_h_nxt  = 1'b1;
                     8'hC0: flip_v_nxt  = 1'b0;
                     8'hC8: flip_v_nxt  = 1'b1;
`endif
                     default: begin
                        // Page-mode pointer shortcuts; anything else is ignored.
                        if (mode == MODE_PAGE) begin
                           if (bus.byte_data[7:4] == 4'h0)
                              col_ptr_nxt[3:0] = bus.byte_data[3:0];
                           else if (bus.byte_data[7:3] == 5'b00010)
                              col_ptr_nxt[COL_W-1:4] = bus.byte_data[COL_W-5:0];
                           else if (bus.byte_data[7:3] == 5'b10110)
                              page_ptr_nxt = bus.byte_data[PAGE_W-1:0];
                        end
                     end
                  endcase
               end
               ARG1: begin
                  state_nxt = IDLE;
                  case (opcode)
                     8'h20: if (bus.byte_data[1:0] != 2'd3) mode_nxt = bus.byte_data[1:0];
                     8'h81: contrast_nxt = bus.byte_data;
                     default: begin
                        arg_nxt   = bus.byte_data[COL_W-1:0];
                        state_nxt = ARG2;
                     end
                  endcase
               end
               ARG2: begin
                  state_nxt = IDLE;
                  if (opcode == 8'h21) begin
                     col_start_nxt = arg;
                     col_end_nxt   = bus.byte_data[COL_W-1:0];
                     col_ptr_nxt   = arg;
                  end else begin
                     page_start_nxt = arg[PAGE_W-1:0];
                     page_end_nxt   = bus.byte_data[PAGE_W-1:0];
                     page_ptr_nxt   = arg[PAGE_W-1:0];
                  end
               end
               default: state_nxt = IDLE;   // SKIP1: argument swallowed
            endcase
         end
      end
      // Transfer end wins over whatever state the byte left behind.
      if (bus.cs_rise) state_nxt = IDLE;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Config, pointer and write-port registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opcode      <= 8'h00;
         arg         <= '0;
         mode        <= MODE_PAGE;
         col_start   <= '0;
         col_end     <= '1;
         col_ptr     <= '0;
         page_start  <= '0;
         page_end    <= '1;
         page_ptr    <= '0;
         disp_on     <= 1'b0;
         invert      <= 1'b0;
         contrast    <= CONTRAST_RST;
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= 8'h00;
      end else begin
         opcode      <= opcode_nxt;
         arg         <= arg_nxt;
         mode        <= mode_nxt;
         col_start   <= col_start_nxt;
         col_end     <= col_end_nxt;
         col_ptr     <= col_ptr_nxt;
         page_start  <= page_start_nxt;
         page_end    <= page_end_nxt;
         page_ptr    <= page_ptr_nxt;
         disp_on     <= disp_on_nxt;
         invert      <= invert_nxt;
         contrast    <= contrast_nxt;
         bus.wr_en   <= wr_en_nxt;
         bus.wr_addr <= wr_addr_nxt;
         bus.wr_data <= wr_data_nxt;
      end
   end

`ifdef SSD1306_CTRL_FLIP_EN
   // Mirror controls for the scan-out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flip_h <= 1'b0;
         flip_v <= 1'b0;
      end else begin
         flip_h <= flip_h_nxt;
         flip_v <= flip_v_nxt;
      end
   end
`else
   assign flip_h = 1'b0;
   assign flip_v = 1'b0;
`endif

endmodule

// File: tb/tb_ssd1306_cmd_ctrl.sv
// Bench for ssd1306_cmd_ctrl: byte-level reference model feeding a write scoreboard.
// Directed sequences first, then randomized command/data streams with cs_rise and gaps.
// The monitor pops expected writes whenever wr_en is seen; config is compared after bytes.
module tb_ssd1306_cmd_ctrl;
   localparam int COL_W  = 7;
   localparam int PAGE_W = 3;

   logic clk = 1'b0;
   logic rst;
   logic disp_on, invert, flip_h, flip_v;
   logic [7:0] contrast;

   int tests = 0;
   int fails = 0;

   ssd1306_cmd_ctrl_if #(.COL_W(COL_W), .PAGE_W(PAGE_W)) bus ();

   ssd1306_cmd_ctrl #(.COL_W(COL_W), .PAGE_W(PAGE_W), .CONTRAST_RST(8'h7F)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .disp_on  (disp_on),
      .invert   (invert),
      .contrast (contrast),
      .flip_h   (flip_h),
      .flip_v   (flip_v)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int m_mode, m_cs, m_ce, m_ps, m_pe, m_col, m_page;
   int m_disp, m_inv, m_con, m_fh, m_fv;
   logic [7:0]  cmdq[$];     // bytes of the command being collected
   logic [17:0] exp_q[$];    // {addr[9:0], data[7:0]}
`ifdef SSD1306_CTRL_FLIP_EN
   localparam bit FLIP_EN = 1'b1;
`else
   localparam bit FLIP_EN = 1'b0;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int nargs(input logic [7:0] op);
      case (op)
         8'h21, 8'h22: return 2;
         8'h20, 8'h81, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D: return 1;
         default: return 0;
      endcase
   endfunction

   function automatic int step(input int p, input int s, input int e, input int modulus);
      return (p == e) ? s : (p + 1) % modulus;
   endfunction

   task automatic model_reset();
      m_mode = 2; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7; m_col = 0; m_page = 0;
      m_disp = 0; m_inv = 0; m_con = 8'h7F; m_fh = 0; m_fv = 0;
      cmdq.delete();
   endtask

   task automatic model_exec();
      logic [7:0] op;
      op = cmdq[0];
      case (op)
         8'h20: if (cmdq[1] % 4 != 3) m_mode = cmdq[1] % 4;
         8'h21: begin m_cs = cmdq[1] % 128; m_ce = cmdq[2] % 128; m_col = m_cs; end
         8'h22: begin m_ps = cmdq[1] % 8; m_pe = cmdq[2] % 8; m_page = m_ps; end
         8'h81: m_con = cmdq[1];
         8'hAE: m_disp = 0;
         8'hAF: m_disp = 1;
         8'hA6: m_inv = 0;
         8'hA7: m_inv = 1;
         8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D: ;
         8'hA0: if (FLIP_EN) m_fh = 0;
         8'hA1: if (FLIP_EN) m_fh = 1;
         8'hC0: if (FLIP_EN) m_fv = 0;
         8'hC8: if (FLIP_EN) m_fv = 1;
         default:
            if (m_mode == 2) begin
               if (op < 16)                    m_col  = (m_col / 16) * 16 + op;
               else if (op >= 16 && op <= 23)  m_col  = (op - 16) * 16 + m_col % 16;
               else if (op >= 176 && op <= 183) m_page = op - 176;
            end
      endcase
   endtask

   task automatic model_byte(input bit dc, input logic [7:0] d);
      bit wrapped;
      if (dc) begin
         exp_q.push_back({10'((m_page << COL_W) | m_col), d});
         cmdq.delete();
         if (m_mode == 0) begin
            wrapped = (m_col == m_ce);
            m_col = step(m_col, m_cs, m_ce, 128);
            if (wrapped) m_page = step(m_page, m_ps, m_pe, 8);
         end else if (m_mode == 1) begin
            wrapped = (m_page == m_pe);
            m_page = step(m_page, m_ps, m_pe, 8);
            if (wrapped) m_col = step(m_col, m_cs, m_ce, 128);
         end else begin
            m_col = step(m_col, m_cs, m_ce, 128);
         end
      end else begin
         cmdq.push_back(d);
         if (cmdq.size() == 1 + nargs(cmdq[0])) begin
            model_exec();
            cmdq.delete();
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic send(input bit dc, input logic [7:0] d, input bit cs = 1'b0);
      bus.byte_valid = 1'b1;
      bus.byte_dc    = dc;
      bus.byte_data  = d;
      bus.cs_rise    = cs;
      model_byte(dc, d);
      if (cs) cmdq.delete();
      @(posedge clk); #1;
      bus.byte_valid = 1'b0;
      bus.cs_rise    = 1'b0;
   endtask

   task automatic cs_pulse();
      bus.cs_rise = 1'b1;
      cmdq.delete();
      @(posedge clk); #1;
      bus.cs_rise = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cmds(input logic [7:0] b[$]);
      foreach (b[i]) send(1'b0, b[i]);
   endtask

   task automatic check_cfg(input string tag);
      check({tag, ".disp_on"},  32'(disp_on),  32'(m_disp));
      check({tag, ".invert"},   32'(invert),   32'(m_inv));
      check({tag, ".contrast"}, 32'(contrast), 32'(m_con));
      check({tag, ".flip_h"},   32'(flip_h),   32'(m_fh));
      check({tag, ".flip_v"},   32'(flip_v),   32'(m_fv));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".wr_en"},   32'(bus.wr_en),   32'd0);
      check({tag, ".wr_addr"}, 32'(bus.wr_addr), 32'd0);
      check({tag, ".wr_data"}, 32'(bus.wr_data), 32'd0);
      check({tag, ".contrast"}, 32'(contrast),   32'h7F);
      check({tag, ".disp_on"}, 32'(disp_on),     32'd0);
   endtask

   // ---------------- write monitor ----------------
   always @(negedge clk) begin
      if (!rst && bus.wr_en) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL write: unexpected write addr 0x%0h data 0x%0h", bus.wr_addr, bus.wr_data);
         end else begin
            check("write", 32'({bus.wr_addr, bus.wr_data}), 32'(exp_q.pop_front()));
         end
      end
   end

   // Hard bound on total run time.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] ops[] = '{8'h20, 8'h21, 8'h22, 8'h81, 8'hA8, 8'hD3, 8'h8D, 8'hAE, 8'hAF,
                           8'hA6, 8'hA7, 8'hA0, 8'hA1, 8'hC0, 8'hC8, 8'h03, 8'h14, 8'hB5};
      rst = 1'b1;
      bus.byte_valid = 1'b0; bus.byte_dc = 1'b0; bus.byte_data = 8'h00; bus.cs_rise = 1'b0;
      model_reset();
      idle(3);
      check_reset_outputs("reset");
      rst = 1'b0;
      idle(1);
      check_cfg("reset");

      // Plain data in page mode from the origin.
      send(1'b1, 8'hAA);
      send(1'b1, 8'h55);
      idle(2);
      check_cfg("data0");

      // Horizontal mode with a 2x2 window in the bottom-right corner, then wrap.
      cmds('{8'h20, 8'h00, 8'h21, 8'h7E, 8'h7F, 8'h22, 8'h06, 8'h07});
      repeat (5) send(1'b1, 8'($urandom));

      // Vertical mode over pages 0..1, columns 0..1.
      cmds('{8'h20, 8'h01, 8'h22, 8'h00, 8'h01, 8'h21, 8'h00, 8'h01});
      repeat (5) send(1'b1, 8'($urandom));

      // Page mode shortcuts with a full column range, then ignored in horizontal mode.
      cmds('{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07, 8'h20, 8'h02, 8'hB3, 8'h05, 8'h12});
      send(1'b1, 8'hFF);
      cmds('{8'h20, 8'h00, 8'hB6});
      send(1'b1, 8'h3C);

      // Pending contrast argument dropped by cs_rise, then by a data byte.
      send(1'b0, 8'h81);
      cs_pulse();
      send(1'b0, 8'hAF);
      check_cfg("cs_abort");
      send(1'b0, 8'h81);
      send(1'b1, 8'h10);
      check_cfg("data_abort");
      // cs_rise together with the argument byte: byte executes first.
      send(1'b0, 8'h81);
      send(1'b0, 8'h44, 1'b1);
      send(1'b0, 8'h5A);
      check_cfg("cs_same_cycle");

      // Skipped argument, inverse, flips.
      cmds('{8'hA8, 8'h3F, 8'hA7});
      check_cfg("skip");
      cmds('{8'hA1, 8'hC8});
      check_cfg("flip");

      // Reset arriving while a write strobe is high.
      idle(2);
      bus.byte_valid = 1'b1; bus.byte_dc = 1'b1; bus.byte_data = 8'h99;
      @(posedge clk); #1;
      bus.byte_valid = 1'b0;
      check("midwrite.wr_en_before", 32'(bus.wr_en), 32'd1);
      rst = 1'b1;
      #1;
      check_reset_outputs("midwrite");
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      check_cfg("midwrite");

      // Randomized mixed streams.
      for (int i = 0; i < 600; i++) begin
         int r;
         bit cs;
         r  = $urandom_range(0, 99);
         cs = ($urandom_range(0, 99) < 4);
         if (r < 45)      send(1'b1, 8'($urandom), cs);
         else if (r < 75) send(1'b0, ops[$urandom_range(0, ops.size() - 1)], cs);
         else             send(1'b0, 8'($urandom), cs);
         if ($urandom_range(0, 99) < 15) idle($urandom_range(1, 3));
         if (i % 60 == 59) check_cfg("random");
      end

      idle(4);
      check("drain", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
